sti_deserializer: RTL and testbench
===================================

// Module: sti_deserializer
// PURPOSE
//  Receive side of the STI serial link: samples si_data while si_valid is high and rebuilds 8/16/24/32-bit words.
//  Bit order and length come from frame config sampled at the first bit.
//  Presents each word on a one-entry held parallel output with valid/ready handshake.
//  Flags truncated frames and output overruns, and counts good frames.
// PARAMETERS
//  FRAME_CNT_W  16  width of frame_cnt (good frames received, wraps)
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  reset        in   1   asynchronous, active-high reset
//  si_data      in   1   serial data bit, valid when si_valid=1
//  si_valid     in   1   bit strobe; high for N consecutive cycles per frame
//  cfg_length   in   2   00=8b 01=16b 10=24b 11=32b (N=8*(cfg_length+1))
//  cfg_msb      in   1   1=MSB-first, 0=LSB-first
//  cfg_fill     in   1   payload placement flag (PAYLOAD_EXTRACT_EN only)
//  cfg_low      in   1   byte-select flag for 8b frames (PAYLOAD_EXTRACT_EN only)
//  po_data      out  32  received word, right-aligned, bits [31:N] zero
//  po_len       out  2   cfg_length of the held word
//  po_valid     out  1   held word available
//  po_ready     in   1   consumer accepts word when po_valid&&po_ready
//  frame_err    out  1   1-cycle pulse: frame truncated
//  overrun      out  1   1-cycle pulse: held word overwritten before accept
//  frame_cnt    out  FRAME_CNT_W  count of completed frames, wraps at 2^W
// BEHAVIOUR
//  Reset: state=IDLE, bit count=0, shift reg=0, po_data=0, po_len=0; all flags 0; frame_cnt=0.
//  FSM IDLE->RECV: on si_valid=1; latch cfg_*; take bit 0 of frame that cycle; count=1.
//  RECV: each si_valid=1 cycle takes one bit, count++.
//   When count reaches N, word completes that cycle.
//  RECV, si_valid=0 with 0<count<N:
//   frame_err pulses next cycle; partial word is discarded; return to IDLE.
//  Completion: state->IDLE, count=0.
//   If si_valid is high the next cycle, that bit starts a new frame (back-to-back frames, no gap needed).
//  MSB-first: sr <= {sr[30:0],si_data}; first bit lands at word[N-1].
//  LSB-first: sr[count] <= si_data; first bit lands at word[0]. Unused bits are cleared at frame start.
//  Output latency: po_valid=1 and po_data/po_len update on the cycle after the last bit; frame_cnt++ on the same edge.
//  po_valid holds, with po_data stable, until po_valid&&po_ready.
//   po_valid then drops next cycle unless a new word completes on the same edge; the new word wins, po_valid stays 1.
//  Completion while po_valid=1 and po_ready=0: new word overwrites the held word; overrun pulses 1 cycle; frame_cnt still ++.
//  Truncated frames do not touch po_*, overrun or frame_cnt.
//  Reset mid-frame or mid-hold: drop everything immediately to the reset values above.
//  frame_cnt wraps from 2^FRAME_CNT_W-1 to 0 silently.
// CONFIGURATION
//  PAYLOAD_EXTRACT_EN defined: extra output po_payload[15:0], updated with po_data. Uses cfg_fill/cfg_low latched at frame start.
//   8b:  cfg_low ? {word[7:0],8'h00} : {8'h00,word[7:0]}
//   16b: word[15:0]
//   24b: cfg_fill ? word[23:8] : word[15:0]
//   32b: cfg_fill ? word[31:16] : word[15:0]
//   po_payload resets to 0.
//  PAYLOAD_EXTRACT_EN undefined: po_payload port absent; cfg_fill/cfg_low ignored.
// TESTING
//  16b MSB-first, bits of 16'hA53C, po_ready=1 -> po_data=32'h0000A53C, po_len=01; po_valid 1 cycle after last bit; frame_cnt=1.
//  8b LSB-first, bits 0,1,0,1,1,0,0,1 -> po_data=32'h0000009A.
//  32b frame 32'hDEADBEEF, then immediate 8b 8'h5A, po_ready=0:
//   second completion gives overrun pulse; po_data=32'h0000005A; frame_cnt=2.
//  24b frame, si_valid drops after 10 bits -> frame_err pulse; po_valid unchanged.
//   Next 8b frame 8'hFF is received correctly.
//  Reset asserted mid 32b frame, then a 16b 16'h1234 frame -> po_data=32'h00001234; frame_cnt=1.
//  PAYLOAD_EXTRACT_EN, 24b cfg_fill=0 word 24'h00BEEF -> po_payload=16'hBEEF.
//   8b cfg_low=1 word 8'h12 -> po_payload=16'h1200.

Source files
------------

// File: rtl/sti_if.sv
// STI receive-side bundle: serial bit stream + frame config in, held parallel word out.
// Carries po_payload only when PAYLOAD_EXTRACT_EN is defined.
interface sti_if #(parameter int FRAME_CNT_W = 16);
  logic                   si_data;
  logic                   si_valid;
  logic [1:0]             cfg_length;
  logic                   cfg_msb;
  logic                   cfg_fill;
  logic                   cfg_low;
  logic [31:0]            po_data;
  logic [1:0]             po_len;
  logic                   po_valid;
  logic                   po_ready;
  logic                   frame_err;
  logic                   overrun;
  logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef PAYLOAD_EXTRACT_EN
  logic [15:0]            po_payload;
`endif

  // master = link/consumer side, slave = deserializer
  modport master (
    output si_data, si_valid, cfg_length, cfg_msb, cfg_fill, cfg_low, po_ready,
    input  po_data, po_len, po_valid, frame_err, overrun, frame_cnt
`ifdef PAYLOAD_EXTRACT_EN
    , input po_payload
`endif
  );
  modport slave (
    input  si_data, si_valid, cfg_length, cfg_msb, cfg_fill, cfg_low, po_ready,
    output po_data, po_len, po_valid, frame_err, overrun, frame_cnt
`ifdef PAYLOAD_EXTRACT_EN
    , output po_payload
`endif
  );
endinterface

// File: rtl/sti_deserializer.sv
// STI serial-to-parallel receiver: 8/16/24/32-bit frames, one-entry held output with valid/ready.
// Optional PAYLOAD_EXTRACT_EN adds a 16-bit payload view of each received word.
module sti_deserializer #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  sti_if.slave bus
);
  typedef enum logic {IDLE, RECV} state_t;

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [31:0]            sr_q, sr_d;
  logic [1:0]             len_q;
  logic                   msb_q;
  logic                   done, trunc;
  logic [5:0]             n_bits;
  logic [31:0]            po_data_q;
  logic [1:0]             po_len_q;
  logic                   po_valid_q, frame_err_q, overrun_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  assign n_bits = {1'b0, len_q, 3'b000} + 6'd8;

  // Shift register starts each frame zeroed apart from the first bit, so bits above N stay 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;
    trunc   = 1'b0;
    case (state_q)
      IDLE: if (bus.si_valid) begin
        state_d = RECV;
        cnt_d   = 6'd1;
        sr_d    = {31'b0, bus.si_data};
      end
      RECV: if (bus.si_valid) begin
        if (msb_q) sr_d = {sr_q[30:0], bus.si_data};
        else       sr_d[cnt_q[4:0]] = bus.si_data;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q + 6'd1 == n_bits) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      end else begin
        trunc   = 1'b1;
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      len_q       <= '0;
      msb_q       <= 1'b0;
      po_data_q   <= '0;
      po_len_q    <= '0;
      po_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      frame_err_q <= trunc;
      overrun_q   <= done && po_valid_q && !bus.po_ready;
      if (state_q == IDLE && bus.si_valid) begin
        len_q <= bus.cfg_length;
        msb_q <= bus.cfg_msb;
      end
      // A completing word wins over a same-cycle accept
      if (done) begin
        po_data_q   <= sr_d;
        po_len_q    <= len_q;
        po_valid_q  <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end else if (po_valid_q && bus.po_ready) begin
        po_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.po_data   = po_data_q;
  assign bus.po_len    = po_len_q;
  assign bus.po_valid  = po_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_cnt = frame_cnt_q;

`ifdef PAYLOAD_EXTRACT_EN
  logic        fill_q, low_q;
  logic [15:0] payload_d, payload_q;

  always_comb begin
    payload_d = sr_d[15:0];
    case (len_q)
      2'd0: payload_d = low_q  ? {sr_d[7:0], 8'h00} : {8'h00, sr_d[7:0]};
      2'd1: payload_d = sr_d[15:0];
      2'd2: payload_d = fill_q ? sr_d[23:8]  : sr_d[15:0];
      2'd3: payload_d = fill_q ? sr_d[31:16] : sr_d[15:0];
      default: payload_d = sr_d[15:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q    <= 1'b0;
      low_q     <= 1'b0;
      payload_q <= '0;
    end else begin
      if (state_q == IDLE && bus.si_valid) begin
        fill_q <= bus.cfg_fill;
        low_q  <= bus.cfg_low;
      end
      if (done) payload_q <= payload_d;
    end
  end

  assign bus.po_payload = payload_q;
`endif
endmodule

// File: tb/tb_sti_deserializer.sv
// Directed bench for sti_deserializer: hand-computed frames, overrun, truncation, reset mid-frame.
module tb_sti_deserializer;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  sti_if #(.FRAME_CNT_W(16)) bus ();
  sti_deserializer #(.FRAME_CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive bits [first, first+nb) of a frame; outputs are sampled 1ns after each edge
  task automatic send(input logic [1:0] len, input logic msb, input logic [31:0] word,
                      input int first, input int nb);
    int n;
    n = 8 * (int'(len) + 1);
    for (int i = first; i < first + nb; i++) begin
      bus.si_valid   = 1'b1;
      bus.cfg_length = len;
      bus.cfg_msb    = msb;
      bus.si_data    = msb ? word[n-1-i] : word[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.si_valid = 1'b0;
    bus.si_data  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.si_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    bus.si_data = 0; bus.si_valid = 0; bus.cfg_length = 0; bus.cfg_msb = 0;
    bus.cfg_fill = 0; bus.cfg_low = 0; bus.po_ready = 1;
    #12;
    check("rst_po_data",   bus.po_data,   32'h0);
    check("rst_po_valid",  bus.po_valid,  32'h0);
    check("rst_po_len",    bus.po_len,    32'h0);
    check("rst_frame_cnt", bus.frame_cnt, 32'h0);
    check("rst_flags",     {bus.frame_err, bus.overrun}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // 16b MSB-first A53C with consumer ready
    send(2'd1, 1'b1, 32'h0000A53C, 0, 15);
    check("a53c_not_yet", bus.po_valid, 32'h0);
    send(2'd1, 1'b1, 32'h0000A53C, 15, 1);
    check("a53c_valid", bus.po_valid,  32'h1);
    check("a53c_data",  bus.po_data,   32'h0000A53C);
    check("a53c_len",   bus.po_len,    32'h1);
    check("a53c_cnt",   bus.frame_cnt, 32'h1);
    idle();
    check("a53c_accept", bus.po_valid, 32'h0);

    // 8b LSB-first bits 0,1,0,1,1,0,0,1
    send(2'd0, 1'b0, 32'h0000009A, 0, 8);
    check("9a_data",  bus.po_data,   32'h0000009A);
    check("9a_len",   bus.po_len,    32'h0);
    check("9a_cnt",   bus.frame_cnt, 32'h2);
    idle();

    // Back-to-back 32b + 8b while consumer stalls
    do_reset();
    bus.po_ready = 1'b0;
    send(2'd3, 1'b1, 32'hDEADBEEF, 0, 32);
    check("dead_data",    bus.po_data, 32'hDEADBEEF);
    check("dead_overrun", bus.overrun, 32'h0);
    send(2'd0, 1'b1, 32'h0000005A, 0, 8);
    check("ovr_pulse", bus.overrun,   32'h1);
    check("ovr_data",  bus.po_data,   32'h0000005A);
    check("ovr_len",   bus.po_len,    32'h0);
    check("ovr_cnt",   bus.frame_cnt, 32'h2);
    idle();
    check("ovr_end",   bus.overrun,   32'h0);
    check("ovr_hold",  bus.po_valid,  32'h1);

    // 24b frame truncated after 10 bits
    send(2'd2, 1'b1, 32'h00ABCDEF, 0, 10);
    check("trunc_no_err_yet", bus.frame_err, 32'h0);
    idle();
    check("trunc_err",   bus.frame_err, 32'h1);
    check("trunc_valid", bus.po_valid,  32'h1);
    check("trunc_data",  bus.po_data,   32'h0000005A);
    check("trunc_cnt",   bus.frame_cnt, 32'h2);
    bus.po_ready = 1'b1;
    idle();
    check("trunc_err_end", bus.frame_err, 32'h0);
    check("trunc_accept",  bus.po_valid,  32'h0);
    send(2'd0, 1'b0, 32'h000000FF, 0, 8);
    check("ff_data",    bus.po_data,   32'h000000FF);
    check("ff_cnt",     bus.frame_cnt, 32'h3);
    check("ff_overrun", bus.overrun,   32'h0);
    idle();

    // Asynchronous reset in the middle of a 32b frame
    send(2'd3, 1'b1, 32'hCAFEF00D, 0, 12);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data",  bus.po_data,   32'h0);
    check("mid_rst_valid", bus.po_valid,  32'h0);
    check("mid_rst_cnt",   bus.frame_cnt, 32'h0);
    bus.si_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send(2'd1, 1'b1, 32'h00001234, 0, 16);
    check("1234_data", bus.po_data,   32'h00001234);
    check("1234_cnt",  bus.frame_cnt, 32'h1);
    idle();

`ifdef PAYLOAD_EXTRACT_EN
    bus.cfg_fill = 1'b0; bus.cfg_low = 1'b0;
    send(2'd2, 1'b1, 32'h0000BEEF, 0, 24);
    check("pl_24_nofill", bus.po_payload, 32'h0000BEEF);
    idle();
    bus.cfg_low = 1'b1;
    send(2'd0, 1'b0, 32'h00000012, 0, 8);
    check("pl_8_low", bus.po_payload, 32'h00001200);
    idle();
    bus.cfg_fill = 1'b1;
    send(2'd3, 1'b1, 32'hDEADBEEF, 0, 32);
    check("pl_32_fill", bus.po_payload, 32'h0000DEAD);
    idle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
